// File: rtl/mem_stage_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit.
// Contents: bytesel size encodings, the LSU FSM state type and the
// data-bus width constants.
package mem_stage_lsu_pkg;

  localparam int unsigned DBUS_DATA_W = 32;
  localparam int unsigned DBUS_BE_W   = DBUS_DATA_W / 8;

  localparam logic [DBUS_BE_W-1:0] BSEL_BYTE = 4'b0001;
  localparam logic [DBUS_BE_W-1:0] BSEL_HALF = 4'b0011;
  localparam logic [DBUS_BE_W-1:0] BSEL_WORD = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_GNT = 2'd1,
    S_WAIT_RV  = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_lane_align.sv
// lsu_lane_align: purely combinational byte-lane steering.
//   bytesel_i   unshifted size mask (byte/half/word)
//   addr_lo_i   address bits [1:0]
//   extsigned_i sign-extend load data when set
//   wdata_i     raw store data (rt)
//   rdata_i     raw bus read data
//   be_o        byte enables = bytesel << addr_lo
//   wdata_o     store data replicated across all lanes of its size
//   ldata_o     load data shifted down, masked to size and extended
module lsu_lane_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [DBUS_BE_W-1:0]   bytesel_i,
  input  logic [1:0]             addr_lo_i,
  input  logic                   extsigned_i,
  input  logic [DBUS_DATA_W-1:0] wdata_i,
  input  logic [DBUS_DATA_W-1:0] rdata_i,
  output logic [DBUS_BE_W-1:0]   be_o,
  output logic [DBUS_DATA_W-1:0] wdata_o,
  output logic [DBUS_DATA_W-1:0] ldata_o
);

  logic [DBUS_DATA_W-1:0] shifted;

  assign be_o    = bytesel_i << addr_lo_i;
  assign shifted = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    wdata_o = wdata_i;
    ldata_o = shifted;
    unique case (bytesel_i)
      BSEL_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        ldata_o = {{24{shifted[7] & extsigned_i}}, shifted[7:0]};
      end
      BSEL_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        ldata_o = {{16{shifted[15] & extsigned_i}}, shifted[15:0]};
      end
      default: begin
        wdata_o = wdata_i;
        ldata_o = shifted;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-stage load/store unit fed by the EX/MEM register.
//   clk, reset           clock; synchronous active-high reset
//   mem_*_i              EX/MEM register outputs for the current instruction
//   dbus_*               req/gnt/rvalid data-bus master port
//   stall_o              holds EX/MEM while an access is outstanding
//   wb_*_o               registered MEM/WB interface
//   exc_adel_o/ades_o    misaligned load/store, one-cycle pulse
//   bus_err_o            bus error or timeout, one-cycle pulse
//   badvaddr_o           faulting address, held until the next fault
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_dmen_i,
  input  logic        mem_memwr_i,
  input  logic        mem_memtoreg_i,
  input  logic        mem_regwr_i,
  input  logic [3:0]  mem_bytesel_i,
  input  logic        mem_extsigned_i,
  input  logic [31:0] mem_result_i,
  input  logic [31:0] mem_rt_i,
  input  logic [4:0]  mem_regdst_addr_i,
  input  logic [31:0] mem_pc_i,
  output logic        dbus_req_o,
  output logic        dbus_we_o,
  output logic [31:0] dbus_addr_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_err_i,
  output logic        stall_o,
  output logic        wb_regwr_o,
  output logic [4:0]  wb_regdst_addr_o,
  output logic [31:0] wb_data_o,
  output logic [31:0] wb_pc_o,
  output logic        exc_adel_o,
  output logic        exc_ades_o,
  output logic        bus_err_o,
  output logic [31:0] badvaddr_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        misaligned;
  logic        req, done, fault_bus, fault_align, timeout_hit;
  logic [31:0] ldata;

  assign misaligned = ((mem_bytesel_i == BSEL_HALF) && mem_result_i[0]) ||
                      ((mem_bytesel_i == BSEL_WORD) && (mem_result_i[1:0] != 2'b00));
  assign timeout_hit = (cnt_q == TO_LAST);

  lsu_lane_align u_align (
    .bytesel_i   (mem_bytesel_i),
    .addr_lo_i   (mem_result_i[1:0]),
    .extsigned_i (mem_extsigned_i),
    .wdata_i     (mem_rt_i),
    .rdata_i     (dbus_rdata_i),
    .be_o        (dbus_be_o),
    .wdata_o     (dbus_wdata_o),
    .ldata_o     (ldata)
  );

  // done marks the cycle the instruction leaves MEM (normally or by fault);
  // rvalid outside WAIT_RV is never looked at.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    req         = 1'b0;
    done        = 1'b0;
    fault_bus   = 1'b0;
    fault_align = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!mem_dmen_i) begin
          done = 1'b1;
        end else if (misaligned) begin
          done        = 1'b1;
          fault_align = 1'b1;
        end else begin
          req = 1'b1;
          if (dbus_gnt_i) begin
            if (mem_memwr_i) begin
              done      = 1'b1;
              fault_bus = dbus_err_i;
            end else begin
              state_d = S_WAIT_RV;
            end
          end else begin
            state_d = S_WAIT_GNT;
          end
        end
      end
      S_WAIT_GNT: begin
        req = 1'b1;
        if (dbus_gnt_i) begin
          if (mem_memwr_i) begin
            done      = 1'b1;
            fault_bus = dbus_err_i;
            state_d   = S_IDLE;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT_RV;
          end
        end else if (timeout_hit) begin
          done      = 1'b1;
          fault_bus = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_WAIT_RV: begin
        if (dbus_rvalid_i) begin
          done      = 1'b1;
          fault_bus = dbus_err_i;
          state_d   = S_IDLE;
        end else if (timeout_hit) begin
          done      = 1'b1;
          fault_bus = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dbus_req_o  = req & ~reset;
  assign dbus_we_o   = req & mem_memwr_i;
  assign dbus_addr_o = {mem_result_i[31:2], 2'b00};
  assign stall_o     = ~done & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      wb_regwr_o       <= 1'b0;
      wb_regdst_addr_o <= '0;
      wb_data_o        <= '0;
      wb_pc_o          <= '0;
      exc_adel_o       <= 1'b0;
      exc_ades_o       <= 1'b0;
      bus_err_o        <= 1'b0;
      badvaddr_o       <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      exc_adel_o <= fault_align & ~mem_memwr_i;
      exc_ades_o <= fault_align & mem_memwr_i;
      bus_err_o  <= fault_bus;
      if (fault_align || fault_bus) begin
        badvaddr_o <= mem_result_i;
      end
      wb_regwr_o <= done & ~fault_align & ~fault_bus & mem_regwr_i;
      if (done) begin
        wb_regdst_addr_o <= mem_regdst_addr_i;
        wb_pc_o          <= mem_pc_i;
        wb_data_o        <= mem_memtoreg_i ? ldata : mem_result_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_dmen, mem_memwr, mem_memtoreg, mem_regwr, mem_extsigned;
  logic [3:0]  mem_bytesel;
  logic [31:0] mem_result, mem_rt, mem_pc;
  logic [4:0]  mem_regdst;
  logic        dbus_req, dbus_we, dbus_gnt, dbus_rvalid, dbus_err;
  logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
  logic [3:0]  dbus_be;
  logic        stall, wb_regwr, exc_adel, exc_ades, bus_err;
  logic [4:0]  wb_regdst;
  logic [31:0] wb_data, wb_pc, badvaddr;

  int tests = 0;
  int fails = 0;
  int sc;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .mem_dmen_i(mem_dmen), .mem_memwr_i(mem_memwr), .mem_memtoreg_i(mem_memtoreg),
    .mem_regwr_i(mem_regwr), .mem_bytesel_i(mem_bytesel), .mem_extsigned_i(mem_extsigned),
    .mem_result_i(mem_result), .mem_rt_i(mem_rt), .mem_regdst_addr_i(mem_regdst),
    .mem_pc_i(mem_pc),
    .dbus_req_o(dbus_req), .dbus_we_o(dbus_we), .dbus_addr_o(dbus_addr),
    .dbus_be_o(dbus_be), .dbus_wdata_o(dbus_wdata), .dbus_gnt_i(dbus_gnt),
    .dbus_rvalid_i(dbus_rvalid), .dbus_rdata_i(dbus_rdata), .dbus_err_i(dbus_err),
    .stall_o(stall), .wb_regwr_o(wb_regwr), .wb_regdst_addr_o(wb_regdst),
    .wb_data_o(wb_data), .wb_pc_o(wb_pc), .exc_adel_o(exc_adel), .exc_ades_o(exc_ades),
    .bus_err_o(bus_err), .badvaddr_o(badvaddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_dmen = 0; mem_memwr = 0; mem_memtoreg = 0; mem_regwr = 0;
    mem_bytesel = 4'b0000; mem_extsigned = 0; mem_result = '0; mem_rt = '0;
    mem_regdst = '0; mem_pc = '0;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = '0; dbus_err = 0;
  endtask

  task automatic drive(input logic dm, input logic wr, input logic m2r, input logic rw,
                       input logic [3:0] bs, input logic ex, input logic [31:0] res,
                       input logic [31:0] rtv, input logic [4:0] rd, input logic [31:0] pc);
    mem_dmen = dm; mem_memwr = wr; mem_memtoreg = m2r; mem_regwr = rw;
    mem_bytesel = bs; mem_extsigned = ex; mem_result = res; mem_rt = rtv;
    mem_regdst = rd; mem_pc = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    reset = 1;
    tick(); tick();
    #1;
    chk("rst_req", dbus_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_regwr", wb_regwr, 0);
    chk("rst_badvaddr", badvaddr, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_wb_data", wb_data, 0);
    reset = 0;
    tick();

    // 1: store byte at 0x1003, granted immediately
    drive(1, 1, 0, 0, 4'b0001, 0, 32'h0000_1003, 32'hAABB_CCDD, 5'd0, 32'h100);
    dbus_gnt = 1;
    #1;
    chk("t1_req", dbus_req, 1);
    chk("t1_we", dbus_we, 1);
    chk("t1_addr", dbus_addr, 32'h0000_1000);
    chk("t1_be", dbus_be, 4'b1000);
    chk("t1_wdata", dbus_wdata, 32'hDDDD_DDDD);
    chk("t1_stall", stall, 0);
    tick(); idle(); #1;
    chk("t1_wb_regwr", wb_regwr, 0);
    chk("t1_wb_pc", wb_pc, 32'h100);

    // 2: signed half load at 0x2002, gnt after 3 cycles, rvalid 2 later
    sc = 0;
    drive(1, 0, 1, 1, 4'b0011, 1, 32'h0000_2002, 32'h0, 5'd5, 32'h200);
    #1;
    chk("t2_req0", dbus_req, 1);
    chk("t2_be", dbus_be, 4'b1100);
    sc += int'(stall);
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t2_req_held", dbus_req, 1);
      sc += int'(stall);
      tick();
    end
    dbus_gnt = 1;
    #1;
    sc += int'(stall);
    tick();
    dbus_gnt = 0;
    #1;
    chk("t2_req_rv", dbus_req, 0);
    chk("t2_bubble", wb_regwr, 0);
    sc += int'(stall);
    tick();
    dbus_rvalid = 1; dbus_rdata = 32'h8001_1234;
    #1;
    chk("t2_stall_done", stall, 0);
    sc += int'(stall);
    tick(); idle(); #1;
    chk("t2_stall_cycles", sc, 5);
    chk("t2_wb_regwr", wb_regwr, 1);
    chk("t2_wb_data_s", wb_data, 32'hFFFF_8001);
    chk("t2_wb_rd", wb_regdst, 5'd5);

    // 2b: same load unsigned, immediate gnt then rvalid
    drive(1, 0, 1, 1, 4'b0011, 0, 32'h0000_2002, 32'h0, 5'd5, 32'h204);
    dbus_gnt = 1;
    tick();
    dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h8001_1234;
    tick(); idle(); #1;
    chk("t2_wb_data_u", wb_data, 32'h0000_8001);

    // signed byte load from lane 1
    drive(1, 0, 1, 1, 4'b0001, 1, 32'h0000_9001, 32'h0, 5'd7, 32'h208);
    dbus_gnt = 1;
    tick();
    dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h0000_8000;
    tick(); idle(); #1;
    chk("byte_sext", wb_data, 32'hFFFF_FF80);

    // 3: misaligned word load
    drive(1, 0, 1, 1, 4'b1111, 0, 32'h0000_3001, 32'h0, 5'd8, 32'h300);
    #1;
    chk("t3_req", dbus_req, 0);
    chk("t3_stall", stall, 0);
    tick(); idle(); #1;
    chk("t3_adel", exc_adel, 1);
    chk("t3_ades", exc_ades, 0);
    chk("t3_badv", badvaddr, 32'h0000_3001);
    chk("t3_wb_regwr", wb_regwr, 0);
    tick(); #1;
    chk("t3_adel_pulse", exc_adel, 0);
    chk("t3_badv_hold", badvaddr, 32'h0000_3001);

    // misaligned half store
    drive(1, 1, 0, 0, 4'b0011, 0, 32'h0000_4001, 32'h1234, 5'd0, 32'h304);
    #1;
    chk("ades_req", dbus_req, 0);
    tick(); idle(); #1;
    chk("ades_pulse", exc_ades, 1);
    chk("ades_badv", badvaddr, 32'h0000_4001);

    // 4: gnt never arrives, timeout of 4
    drive(1, 0, 1, 1, 4'b1111, 0, 32'h0000_5000, 32'h0, 5'd9, 32'h400);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_stall", stall, (i < 4) ? 1 : 0);
      tick();
    end
    idle(); #1;
    chk("t4_bus_err", bus_err, 1);
    chk("t4_badv", badvaddr, 32'h0000_5000);
    chk("t4_wb_regwr", wb_regwr, 0);
    tick(); #1;
    chk("t4_bus_err_pulse", bus_err, 0);
    chk("t4_idle_stall", stall, 0);

    // store answered with a bus error
    drive(1, 1, 0, 0, 4'b1111, 0, 32'h0000_6000, 32'h55, 5'd0, 32'h500);
    dbus_gnt = 1; dbus_err = 1;
    tick(); idle(); #1;
    chk("err_bus_err", bus_err, 1);
    chk("err_badv", badvaddr, 32'h0000_6000);

    // 5: reset while in WAIT_RV, late rvalid after release
    drive(1, 0, 1, 1, 4'b1111, 0, 32'h0000_7000, 32'h0, 5'd10, 32'h600);
    dbus_gnt = 1;
    tick();
    dbus_gnt = 0;
    reset = 1;
    #1;
    chk("t5_stall_rst", stall, 0);
    chk("t5_req_rst", dbus_req, 0);
    tick();
    reset = 0;
    idle();
    tick();
    dbus_rvalid = 1; dbus_rdata = 32'hDEAD_BEEF;
    #1;
    chk("t5_stall_late", stall, 0);
    tick(); idle(); #1;
    chk("t5_wb_regwr", wb_regwr, 0);
    chk("t5_wb_data", wb_data, 0);
    chk("t5_badv", badvaddr, 0);
    chk("t5_bus_err", bus_err, 0);

    // 6: ALU, load, ALU, load back to back
    drive(0, 0, 0, 1, 4'b0000, 0, 32'h1111_1111, 32'h0, 5'd3, 32'h700);
    #1;
    chk("t6_alu_stall", stall, 0);
    tick();
    drive(1, 0, 1, 1, 4'b1111, 0, 32'h0000_8000, 32'h0, 5'd4, 32'h704);
    dbus_gnt = 1;
    #1;
    chk("t6_alu_wb", wb_data, 32'h1111_1111);
    chk("t6_alu_regwr", wb_regwr, 1);
    chk("t6_ld_stall", stall, 1);
    tick();
    dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'hCAFE_F00D;
    #1;
    chk("t6_ld_done", stall, 0);
    chk("t6_bubble", wb_regwr, 0);
    tick();
    idle();
    drive(0, 0, 0, 1, 4'b0000, 0, 32'h2222_2222, 32'h0, 5'd6, 32'h708);
    #1;
    chk("t6_ld_wb", wb_data, 32'hCAFE_F00D);
    chk("t6_ld_rd", wb_regdst, 5'd4);
    chk("t6_ld_regwr", wb_regwr, 1);
    tick();
    drive(1, 0, 1, 1, 4'b1111, 0, 32'h0000_8004, 32'h0, 5'd11, 32'h70C);
    dbus_gnt = 1;
    #1;
    chk("t6_alu2_wb", wb_data, 32'h2222_2222);
    chk("t6_alu2_rd", wb_regdst, 5'd6);
    tick();
    dbus_gnt = 0; dbus_rvalid = 1; dbus_rdata = 32'h0BAD_C0DE;
    tick(); idle(); #1;
    chk("t6_ld2_wb", wb_data, 32'h0BAD_C0DE);
    chk("t6_ld2_rd", wb_regdst, 5'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
